// File: rtl/clock_time_ctrl_pkg.sv
// clock_pkg: shared types and constants for the HH:MM:SS timekeeping block.
//   mode_e     : RUN / SET_HR / SET_MIN / SET_SEC. The encoding is also the
//                external 2-bit mode output.
//   *_MAX      : field maxima used by the equality wrap compares.
//   next_mode  : the mode_btn rotation RUN->SET_HR->SET_MIN->SET_SEC->RUN.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_e;

    localparam int SEC_LO_MAX = 9;
    localparam int SEC_HI_MAX = 5;
    localparam int HR_HI_MAX  = 2;
    localparam int HR_LO_WRAP = 3;
    // Units digit of the hours is plain decimal below the 23 wrap.
    localparam int BCD_MAX    = 9;

    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_SEC;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if: groups the timebase/button inputs and the display
// outputs of clock_time_ctrl.
//   master : environment side. It drives tick/mode_btn/inc_btn and reads the display.
//   slave  : controller side.
//   tick, mode_btn, inc_btn : single-cycle pulses
//   sec_lo/sec_hi/min_lo/min_hi/hr_lo/hr_hi : BCD digits
//   mode : current mode (clock_pkg::mode_e encoding)
//   day_carry : one-cycle pulse on the midnight rollover
//   chime : present only when CLOCK_CHIME_EN is defined
interface clock_time_ctrl_if;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [3:0] sec_lo;
    logic [2:0] sec_hi;
    logic [3:0] min_lo;
    logic [2:0] min_hi;
    logic [3:0] hr_lo;
    logic [1:0] hr_hi;
    logic [1:0] mode;
    logic       day_carry;
`ifdef CLOCK_CHIME_EN
    logic       chime;

    modport master (
        output tick, mode_btn, inc_btn,
        input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, day_carry, chime
    );
    modport slave (
        input  tick, mode_btn, inc_btn,
        output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, day_carry, chime
    );
`else
    modport master (
        output tick, mode_btn, inc_btn,
        input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, day_carry
    );
    modport slave (
        input  tick, mode_btn, inc_btn,
        output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, day_carry
    );
`endif
endinterface

// File: rtl/clock_time_ctrl_digit_counter.sv
// digit_counter: a single mod-MOD counter digit, W bits wide.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one and wrap MOD-1 -> 0
//   clr      : synchronous clear. It has priority over en.
//   q        : digit value, always in 0..MOD-1
//   carry    : combinational, en && q == MOD-1. It drives the next digit's en.
module digit_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         carry
);
    localparam logic [W-1:0] MAX = W'(MOD - 1);

    assign carry = en && (q == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= (q == MAX) ? '0 : q + 1'b1;
    end
endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM:SS timekeeping controller with a run/set mode FSM.
//   clk, rst : clock, asynchronous active-high reset
//   ctl      : clock_time_ctrl_if.slave. It carries the tick/mode_btn/inc_btn
//              inputs and the digit, mode and day_carry outputs.
//   TICK_DIV : tick pulses per one-second advance (1..255)
// Optional: define CLOCK_CHIME_EN to add ctl.chime. It pulses one cycle when a
// RUN advance lands on mm:ss = 00:00.
// Every output is a register, so an event is visible one edge after its inputs.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    clock_time_ctrl_if.slave  ctl
);
    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    mode_e state, state_nxt;
    logic  run, inc_eff, inc_hr, inc_min, clr_sec;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // mode_btn beats inc_btn. The dropped inc is masked here so that it
    // never reaches the field logic of the old or the new mode.
    assign inc_eff = ctl.inc_btn & ~ctl.mode_btn;

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        inc_hr    = 1'b0;
        inc_min   = 1'b0;
        clr_sec   = 1'b0;
        if (ctl.mode_btn) state_nxt = next_mode(state);
        case (state)
            RUN:     run     = 1'b1;
            SET_HR:  inc_hr  = inc_eff;
            SET_MIN: inc_min = inc_eff;
            SET_SEC: clr_sec = inc_eff;
            default: ;
        endcase
    end

    // Prescaler. It counts only in RUN, holds in the set modes and is
    // cleared with the seconds, so a full TICK_DIV period follows a seconds
    // clear.
    logic [7:0] presc;
    logic       sec_en;

    assign sec_en = run & ctl.tick & (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                presc <= '0;
        else if (clr_sec)       presc <= '0;
        else if (run && ctl.tick)
            presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end

    // Seconds / minutes chain
    logic [3:0] sec_lo, min_lo;
    logic [2:0] sec_hi, min_hi;
    logic       sec_lo_c, sec_hi_c, min_lo_c, min_hi_c;

    digit_counter #(.MOD(SEC_LO_MAX + 1), .W(4)) u_sec_lo (
        .clk(clk), .rst(rst), .en(sec_en), .clr(clr_sec),
        .q(sec_lo), .carry(sec_lo_c)
    );
    digit_counter #(.MOD(SEC_HI_MAX + 1), .W(3)) u_sec_hi (
        .clk(clk), .rst(rst), .en(sec_lo_c), .clr(clr_sec),
        .q(sec_hi), .carry(sec_hi_c)
    );
    // sec_hi_c can only fire in RUN because sec_en is gated by run. inc_min
    // joins the chain at the minutes units.
    digit_counter #(.MOD(SEC_LO_MAX + 1), .W(4)) u_min_lo (
        .clk(clk), .rst(rst), .en(sec_hi_c | inc_min), .clr(1'b0),
        .q(min_lo), .carry(min_lo_c)
    );
    digit_counter #(.MOD(SEC_HI_MAX + 1), .W(3)) u_min_hi (
        .clk(clk), .rst(rst), .en(min_lo_c), .clr(1'b0),
        .q(min_hi), .carry(min_hi_c)
    );

    // Hours pair. The 23 -> 00 wrap does not fit the digit_counter model.
    // A minutes wrap in SET_MIN must not reach the hours, so the carry path
    // is gated by run.
    logic [3:0] hr_lo;
    logic [1:0] hr_hi;
    logic       hr_wrap, hr_step, run_wrap;

    assign hr_wrap  = (hr_hi == 2'(HR_HI_MAX)) && (hr_lo == 4'(HR_LO_WRAP));
    assign run_wrap = run & min_hi_c;
    assign hr_step  = run_wrap | inc_hr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_lo <= '0;
            hr_hi <= '0;
        end else if (hr_step) begin
            if (hr_wrap) begin
                hr_lo <= '0;
                hr_hi <= '0;
            end else if (hr_lo == 4'(BCD_MAX)) begin
                hr_lo <= '0;
                hr_hi <= hr_hi + 1'b1;
            end else begin
                hr_lo <= hr_lo + 1'b1;
            end
        end
    end

    // day_carry is registered alongside the digits. It is therefore high in
    // exactly the cycle that first shows 00:00:00.
    logic day_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) day_carry <= 1'b0;
        else     day_carry <= run_wrap & hr_wrap;
    end

`ifdef CLOCK_CHIME_EN
    // A run-mode minutes-tens carry means minutes and seconds both just
    // wrapped, so the display lands on mm:ss = 00:00.
    logic chime;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chime <= 1'b0;
        else     chime <= run_wrap;
    end

    assign ctl.chime = chime;
`endif

    assign ctl.sec_lo    = sec_lo;
    assign ctl.sec_hi    = sec_hi;
    assign ctl.min_lo    = min_lo;
    assign ctl.min_hi    = min_hi;
    assign ctl.hr_lo     = hr_lo;
    assign ctl.hr_hi     = hr_hi;
    assign ctl.mode      = state;
    assign ctl.day_carry = day_carry;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl. dut_a runs with TICK_DIV=1 and dut_b
// with TICK_DIV=4. Both share clock and reset. Inputs change 1 ns after a
// rising edge and are checked there as well.
module tb_clock_time_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    clock_time_ctrl_if ia ();
    clock_time_ctrl_if ib ();

    clock_time_ctrl #(.TICK_DIV(1)) dut_a (.clk(clk), .rst(rst), .ctl(ia));
    clock_time_ctrl #(.TICK_DIV(4)) dut_b (.clk(clk), .rst(rst), .ctl(ib));

    logic [19:0] ta, tbt;
    assign ta  = {ia.hr_hi, ia.hr_lo, ia.min_hi, ia.min_lo, ia.sec_hi, ia.sec_lo};
    assign tbt = {ib.hr_hi, ib.hr_lo, ib.min_hi, ib.min_lo, ib.sec_hi, ib.sec_lo};

    function automatic logic [19:0] hms(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pa(input logic t, input logic m, input logic i);
        ia.tick = t; ia.mode_btn = m; ia.inc_btn = i;
        @(posedge clk); #1;
        ia.tick = 1'b0; ia.mode_btn = 1'b0; ia.inc_btn = 1'b0;
    endtask

    task automatic pb(input logic t, input logic m, input logic i);
        ib.tick = t; ib.mode_btn = m; ib.inc_btn = i;
        @(posedge clk); #1;
        ib.tick = 1'b0; ib.mode_btn = 1'b0; ib.inc_btn = 1'b0;
    endtask

    task automatic tick_a(input int n);
        repeat (n) pa(1'b1, 1'b0, 1'b0);
    endtask

    task automatic inc_a(input int n);
        repeat (n) pa(1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick_b(input int n);
        repeat (n) pb(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        ia.tick = 1'b0; ia.mode_btn = 1'b0; ia.inc_btn = 1'b0;
        ib.tick = 1'b0; ib.mode_btn = 1'b0; ib.inc_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_time_a", ta, hms(0, 0, 0));
        chk("rst_mode_a", ia.mode, 0);
        chk("rst_dc_a", ia.day_carry, 0);
        chk("rst_time_b", tbt, hms(0, 0, 0));
        chk("rst_mode_b", ib.mode, 0);
`ifdef CLOCK_CHIME_EN
        chk("rst_chime_a", ia.chime, 0);
`endif

        // tick+mode in RUN: the advance and the mode change land together
        tick_a(5);
        pa(1'b1, 1'b1, 1'b0);
        chk("tick_mode_time", ta, hms(0, 0, 6));
        chk("tick_mode_mode", ia.mode, 1);

        // async reset mid-cycle aborts set mode and zeroes at once
        #3 rst = 1'b1;
        #1;
        chk("async_rst_time", ta, hms(0, 0, 0));
        chk("async_rst_mode", ia.mode, 0);
        chk("async_rst_dc", ia.day_carry, 0);
        @(posedge clk); #1 rst = 1'b0;

        // seconds -> minutes carry
        tick_a(58);
        chk("sec58", ta, hms(0, 0, 58));
        tick_a(1);
        chk("sec59", ta, hms(0, 0, 59));
        tick_a(1);
        chk("min_carry", ta, hms(0, 1, 0));
        chk("min_carry_dc", ia.day_carry, 0);

        // preload 23:59:59 through the set modes
        pa(1'b1, 1'b1, 1'b0);
        chk("enter_set_time", ta, hms(0, 1, 1));
        inc_a(23);
        chk("set_hr23", ta, hms(23, 1, 1));
        pa(1'b0, 1'b1, 1'b0);
        chk("mode_set_min", ia.mode, 2);
        inc_a(58);
        chk("set_min59", ta, hms(23, 59, 1));
        pa(1'b0, 1'b1, 1'b0);
        chk("mode_set_sec", ia.mode, 3);
        inc_a(1);
        chk("sec_clear", ta, hms(23, 59, 0));
        pa(1'b0, 1'b1, 1'b0);
        chk("mode_run", ia.mode, 0);
        tick_a(59);
        chk("pre_roll", ta, hms(23, 59, 59));
        chk("pre_roll_dc", ia.day_carry, 0);

        // midnight rollover
        tick_a(1);
        chk("roll_time", ta, hms(0, 0, 0));
        chk("roll_dc", ia.day_carry, 1);
`ifdef CLOCK_CHIME_EN
        chk("roll_chime", ia.chime, 1);
`endif
        pa(1'b0, 1'b0, 1'b0);
        chk("roll_dc_drop", ia.day_carry, 0);
        chk("roll_hold", ta, hms(0, 0, 0));
`ifdef CLOCK_CHIME_EN
        chk("roll_chime_drop", ia.chime, 0);
`endif

        // SET_HR: 22 -> 23 -> 00 -> ... -> 23, no carry, ticks ignored
        pa(1'b0, 1'b1, 1'b0);
        inc_a(22);
        chk("hr22", ta, hms(22, 0, 0));
        inc_a(1);
        chk("hr23", ta, hms(23, 0, 0));
        inc_a(1);
        chk("hr_wrap", ta, hms(0, 0, 0));
        chk("hr_wrap_dc", ia.day_carry, 0);
        inc_a(23);
        chk("hr25_end", ta, hms(23, 0, 0));
        tick_a(3);
        chk("set_tick_ign", ta, hms(23, 0, 0));
        chk("set_tick_mode", ia.mode, 1);

        // SET_MIN wrap with no carry into hours; mode_btn beats inc_btn
        pa(1'b0, 1'b1, 1'b0);
        inc_a(59);
        chk("min59", ta, hms(23, 59, 0));
        inc_a(1);
        chk("min_wrap", ta, hms(23, 0, 0));
        chk("min_wrap_dc", ia.day_carry, 0);
        inc_a(1);
        chk("min01", ta, hms(23, 1, 0));
        pa(1'b0, 1'b1, 1'b1);
        chk("mode_inc_mode", ia.mode, 3);
        chk("mode_inc_time", ta, hms(23, 1, 0));

        // inc_btn in RUN has no effect
        pa(1'b0, 1'b1, 1'b0);
        pa(1'b0, 1'b0, 1'b1);
        chk("run_inc_time", ta, hms(23, 1, 0));
        chk("run_inc_mode", ia.mode, 0);

        // TICK_DIV = 4
        tick_b(8);
        chk("div4_8", tbt, hms(0, 0, 2));
        tick_b(2);
        chk("div4_partial", tbt, hms(0, 0, 2));
        repeat (3) pb(1'b0, 1'b1, 1'b0);
        chk("div4_set_sec", ib.mode, 3);
        pb(1'b0, 1'b0, 1'b1);
        chk("div4_clear", tbt, hms(0, 0, 0));
        tick_b(2);
        chk("div4_set_ign", tbt, hms(0, 0, 0));
        pb(1'b0, 1'b1, 1'b0);
        chk("div4_run", ib.mode, 0);
        tick_b(3);
        chk("div4_3ticks", tbt, hms(0, 0, 0));
        tick_b(1);
        chk("div4_4ticks", tbt, hms(0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping controller for an HH:MM:SS display.
- Sequences six cascaded BCD digit counters: seconds/minutes as mod-10 + mod-6 pairs, hours as 00–23.
- Owns the run/set mode state machine that decides when each counter advances and which field the user edits.
- Sits between the 1 Hz tick source and the seven-segment driver.

Parameters:
- TICK_DIV, 1: number of tick pulses per one-second advance; legal range 1–255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick  in  1  single-cycle timebase pulse
- mode_btn  in  1  single-cycle debounced pulse; advances mode
- inc_btn  in  1  single-cycle debounced pulse; increments the selected field
- sec_lo  out  4  seconds units, BCD 0–9
- sec_hi  out  3  seconds tens, 0–5
- min_lo  out  4  minutes units, 0–9
- min_hi  out  3  minutes tens, 0–5
- hr_lo  out  4  hours units, 0–9
- hr_hi  out  2  hours tens, 0–2
- mode  out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
- day_carry  out  1  one-cycle pulse on the 23:59:59→00:00:00 rollover

Behaviour:
- Reset: all digit outputs 0, mode = RUN, day_carry = 0, prescaler = 0. Reset mid-operation aborts any set mode immediately.
- All outputs are registered. A qualifying event is visible on the next clk edge; latency is 1 cycle.
- Prescaler:
  - Counts tick pulses from 0 to TICK_DIV-1 and emits an internal sec_en when it wraps.
  - TICK_DIV = 1: sec_en equals tick.
  - Counts only in RUN; holds its value in the set states.
- RUN, on sec_en:
  - sec_lo increments and wraps 9→0 with a carry.
  - The carry increments sec_hi, which wraps 5→0 with a carry.
  - Minutes follow the same rule.
  - Hours: hr_lo increments. At hr_hi=2, hr_lo=3 the hours wrap to 00 with day_carry.
  - Otherwise hr_lo 9→0 increments hr_hi.
  - All digits of one advance update on the same edge. There are no intermediate values.
- day_carry is high for exactly the one cycle in which the display shows 00:00:00 after a rollover.
- Set states:
  - tick is ignored and the clock is paused.
  - inc_btn in SET_HR increments hours 00→23→00 with no carry.
  - inc_btn in SET_MIN increments minutes 00→59→00 with no carry into hours.
  - inc_btn in SET_SEC clears seconds to 00 and clears the prescaler.
  - day_carry never asserts in set states.
- Mode transitions on mode_btn: RUN→SET_HR→SET_MIN→SET_SEC→RUN.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: mode_btn wins and inc_btn is dropped.
  - tick and mode_btn in RUN: the second advance is applied and the mode moves to SET_HR on the same edge.
  - inc_btn in RUN has no effect.
- Digit values outside their legal range cannot be produced. All wrap compares use equality against the field maximum.

Optional Feature:
- Macro: CLOCK_CHIME_EN.
- Defined: adds output chime (1 bit, reset 0). chime pulses for one cycle when a RUN advance lands on mm:ss = 00:00, including the day rollover.
- Undefined: the port and its logic are absent.

Decomposition:
- Package clock_pkg:
  - mode enum, 2-bit: RUN, SET_HR, SET_MIN, SET_SEC.
  - Constants: SEC_LO_MAX=9, SEC_HI_MAX=5, HR_HI_MAX=2, HR_LO_WRAP=3.
- Sub-module digit_counter:
  - Parameters: MOD and W.
  - Inputs: en, clr.
  - Outputs: q, carry. carry is combinational: en and q==MOD-1.
  - Instantiated for each seconds/minutes digit.
- The hours pair and the FSM live in the top level, because of the 23 wrap.

Test Plan:
- Reset with rst asserted asynchronously mid-cycle → all digits 0 at once, mode=0, day_carry=0.
- TICK_DIV=1; preload 00:00:58, two ticks → 00:00:59, then 00:01:00. Both visible one cycle after each tick.
- Preload 23:59:59 in RUN, one tick → 00:00:00. day_carry high exactly one cycle. With CLOCK_CHIME_EN, chime also pulses.
- mode_btn once, then inc_btn ×25 from hours 22 → hours 23, 00, …, ending at 23. Minutes and seconds unchanged. Ticks during set are ignored.
- In SET_MIN at 59, inc_btn → minutes 00 with hours unchanged. mode_btn+inc_btn in the same cycle → mode advances to SET_SEC and minutes are unchanged.
- TICK_DIV=4, RUN: 8 ticks → seconds +2. Enter SET_SEC, inc_btn → seconds 00. Return to RUN → the next advance occurs after 4 ticks.
